// File: rtl/sweeper_pkg.sv
// Shared types and elaboration-time pyramid geometry for the multiscale window sweeper.
package sweeper_pkg;

  localparam int CNT_W   = 16;
  localparam int RATIO_W = 22;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_FLUSH} sweep_state_t;

  function automatic int sc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // floor(dim * q^s) with q in Q0.16, accumulated with 32 fractional bits.
  function automatic int scaled_dim(input int dim, input int q16, input int s);
    longint acc;
    acc = longint'(dim) <<< 32;
    for (int i = 0; i < s; i++) acc = (acc * longint'(q16)) >>> 16;
    return int'(acc >>> 32);
  endfunction

  function automatic int span(input int dim, input int q16, input int s, input int win);
    return scaled_dim(dim, q16, s) - win;
  endfunction

  function automatic int hop_max(input int bound, input int stride);
    return (bound / stride) * stride;
  endfunction

  function automatic int ratio(input int dim, input int q16, input int s);
    return ((dim <<< 16) / scaled_dim(dim, q16, s)) + 1;
  endfunction

endpackage

// File: rtl/stride_counter.sv
// Wrapping up-counter with programmable step and inclusive maximum.
module stride_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] step,
  input  logic [W-1:0] max,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W:0] sum;

  assign sum  = {1'b0, count} + {1'b0, step};
  assign wrap = (sum > {1'b0, max});

  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (inc) count <= wrap ? '0 : sum[W-1:0];
  end

endmodule

// File: rtl/multiscale_sweeper.sv
// Sweeps every pixel of every detection window across an image pyramid and maps
// each scaled coordinate back to the source image, with valid/ready output.
module multiscale_sweeper
  import sweeper_pkg::*;
#(
  parameter int IMG_WIDTH  = 41,
  parameter int IMG_HEIGHT = 50,
  parameter int WIN_W      = 25,
  parameter int WIN_H      = 25,
  parameter int STRIDE_X   = 1,
  parameter int STRIDE_Y   = 2,
  parameter int SCALE_NUM  = 2,
  parameter int SCALE_Q16  = 49152
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                addr_valid,
  input  logic                                addr_ready,
  output logic [$clog2(IMG_WIDTH)-1:0]        x,
  output logic [$clog2(IMG_HEIGHT)-1:0]       y,
  output logic [sc_width(SCALE_NUM)-1:0]      scale,
  output logic                                win_first,
  output logic                                win_last,
  output logic                                frame_last
);

  localparam int XW   = $clog2(IMG_WIDTH);
  localparam int YW   = $clog2(IMG_HEIGHT);
  localparam int SW_W = sc_width(SCALE_NUM);
  localparam int PW   = CNT_W + 1 + RATIO_W;

  logic [CNT_W-1:0]   hx_max_tab [SCALE_NUM];
  logic [CNT_W-1:0]   hy_max_tab [SCALE_NUM];
  logic [RATIO_W-1:0] rx_tab     [SCALE_NUM];
  logic [RATIO_W-1:0] ry_tab     [SCALE_NUM];

  for (genvar g = 0; g < SCALE_NUM; g++) begin : g_scale
    localparam int BXG = span(IMG_WIDTH,  SCALE_Q16, g, WIN_W);
    localparam int BYG = span(IMG_HEIGHT, SCALE_Q16, g, WIN_H);
    if (BXG < 0 || BYG < 0) begin : g_bad
      $error("detection window does not fit scaled image at scale %0d", g);
    end
    assign hx_max_tab[g] = CNT_W'(hop_max(BXG, STRIDE_X));
    assign hy_max_tab[g] = CNT_W'(hop_max(BYG, STRIDE_Y));
    assign rx_tab[g]     = RATIO_W'(ratio(IMG_WIDTH,  SCALE_Q16, g));
    assign ry_tab[g]     = RATIO_W'(ratio(IMG_HEIGHT, SCALE_Q16, g));
  end

  function automatic logic [XW-1:0] sat_x(input logic [PW-1:0] v);
    if (v > PW'(IMG_WIDTH - 1)) return XW'(IMG_WIDTH - 1);
    return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] sat_y(input logic [PW-1:0] v);
    if (v > PW'(IMG_HEIGHT - 1)) return YW'(IMG_HEIGHT - 1);
    return v[YW-1:0];
  endfunction

  sweep_state_t     state;
  logic             adv;
  logic [CNT_W-1:0] px_cnt, py_cnt, hx_cnt, hy_cnt;
  logic             px_wrap, py_wrap, hx_wrap, hy_wrap;
  logic [SW_W-1:0]  sc_cnt;
  logic             last_scale;

  // Counters hold the coordinate to present on the next load, one ahead of the outputs.
  assign adv = ((state == ST_IDLE) && start) ||
               ((state == ST_SWEEP) && addr_valid && addr_ready && !frame_last);
  assign last_scale = (sc_cnt == SW_W'(SCALE_NUM - 1));

  stride_counter #(.W(CNT_W)) u_px (
    .clk(clk), .rst(rst), .step(CNT_W'(1)), .max(CNT_W'(WIN_W - 1)),
    .inc(adv), .count(px_cnt), .wrap(px_wrap));
  stride_counter #(.W(CNT_W)) u_py (
    .clk(clk), .rst(rst), .step(CNT_W'(1)), .max(CNT_W'(WIN_H - 1)),
    .inc(adv && px_wrap), .count(py_cnt), .wrap(py_wrap));
  stride_counter #(.W(CNT_W)) u_hx (
    .clk(clk), .rst(rst), .step(CNT_W'(STRIDE_X)), .max(hx_max_tab[sc_cnt]),
    .inc(adv && px_wrap && py_wrap), .count(hx_cnt), .wrap(hx_wrap));
  stride_counter #(.W(CNT_W)) u_hy (
    .clk(clk), .rst(rst), .step(CNT_W'(STRIDE_Y)), .max(hy_max_tab[sc_cnt]),
    .inc(adv && px_wrap && py_wrap && hx_wrap), .count(hy_cnt), .wrap(hy_wrap));

  always_ff @(posedge clk) begin
    if (rst) sc_cnt <= '0;
    else if (adv && px_wrap && py_wrap && hx_wrap && hy_wrap)
      sc_cnt <= last_scale ? '0 : sc_cnt + SW_W'(1);
  end

  logic [CNT_W:0] x_sum, y_sum;
  logic [PW-1:0]  x_prod, y_prod;
  logic [XW-1:0]  x_nxt;
  logic [YW-1:0]  y_nxt;
  logic           wf_nxt, wl_nxt, fl_nxt;

  assign x_sum  = {1'b0, hx_cnt} + {1'b0, px_cnt};
  assign y_sum  = {1'b0, hy_cnt} + {1'b0, py_cnt};
  assign x_prod = PW'(x_sum) * PW'(rx_tab[sc_cnt]);
  assign y_prod = PW'(y_sum) * PW'(ry_tab[sc_cnt]);
  assign x_nxt  = sat_x(x_prod >> 16);
  assign y_nxt  = sat_y(y_prod >> 16);
  assign wf_nxt = (px_cnt == '0) && (py_cnt == '0);
  assign wl_nxt = px_wrap && py_wrap;
  assign fl_nxt = wl_nxt && hx_wrap && hy_wrap && last_scale;

  // Output stage: everything is registered and only changes on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_valid <= 1'b0;
      x          <= '0;
      y          <= '0;
      scale      <= '0;
      win_first  <= 1'b0;
      win_last   <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      done <= 1'b0;
      if (adv) begin
        x          <= x_nxt;
        y          <= y_nxt;
        scale      <= sc_cnt;
        win_first  <= wf_nxt;
        win_last   <= wl_nxt;
        frame_last <= fl_nxt;
      end
      case (state)
        ST_IDLE: if (start) begin
          state      <= ST_SWEEP;
          busy       <= 1'b1;
          addr_valid <= 1'b1;
        end
        ST_SWEEP: if (addr_valid && addr_ready && frame_last) begin
          state      <= ST_FLUSH;
          busy       <= 1'b0;
          addr_valid <= 1'b0;
          done       <= 1'b1;
          win_first  <= 1'b0;
          win_last   <= 1'b0;
          frame_last <= 1'b0;
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
